// File: rtl/clock_gen_pkg.sv
// Shared types and defaults for the multi-channel clock generator.
// Imported by the channel divider and the top level.
package clock_gen_pkg;

   typedef enum logic {
      ST_OFF = 1'b0,
      ST_RUN = 1'b1
   } ch_state_e;

   localparam int unsigned DEFAULT_DIV_W = 8;

   // Channel-select width; a single channel still gets a 1-bit select.
   function automatic int unsigned ch_sel_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clock_div_channel.sv
// One divided-clock channel: OFF/RUN FSM, half-period counter and pending-ratio register.
// Ratio changes and stops only take effect on the falling boundary, so phases are never cut short.
module clock_div_channel
   import clock_gen_pkg::*;
#(
   parameter int unsigned DIV_W       = DEFAULT_DIV_W,
   parameter int unsigned DEFAULT_DIV = 0
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             wr,
   input  logic [DIV_W-1:0] wr_div,
   input  logic             wr_en,
   output logic             clk_out,
   output logic             clk_oe_n,
   output logic             tick,
   output logic             running
);

   ch_state_e        state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] act_r_q, act_r_d;
   logic [DIV_W-1:0] pend_r_q, pend_r_d;
   logic             pend_v_q, pend_v_d;
   logic             en_q, en_d;
   logic             clk_q, clk_d;
   logic             oe_n_q, oe_n_d;
   logic             tick_q, tick_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      act_r_d  = act_r_q;
      pend_r_d = pend_r_q;
      pend_v_d = pend_v_q;
      en_d     = en_q;
      clk_d    = clk_q;
      oe_n_d   = oe_n_q;
      tick_d   = 1'b0;

      unique case (state_q)
         ST_OFF: begin
            clk_d  = 1'b0;
            cnt_d  = '0;
            oe_n_d = 1'b1;
            if (en_q) begin
               state_d = ST_RUN;
               oe_n_d  = 1'b0;
               if (pend_v_q) begin
                  act_r_d  = pend_r_q;
                  pend_v_d = 1'b0;
               end
            end
         end
         ST_RUN: begin
            if (cnt_q == act_r_q) begin
               cnt_d = '0;
               clk_d = ~clk_q;
               if (!clk_q) begin
                  tick_d = 1'b1;
               end else begin
                  // Falling toggle: the only point where ratio or enable may change.
                  if (pend_v_q) begin
                     act_r_d  = pend_r_q;
                     pend_v_d = 1'b0;
                  end
                  if (!en_q) begin
                     state_d = ST_OFF;
                  end
               end
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
      endcase

      // A write on a boundary edge becomes the new pending value after the old one is consumed.
      if (wr) begin
         pend_r_d = wr_div;
         pend_v_d = 1'b1;
         en_d     = wr_en;
      end
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_OFF;
         cnt_q    <= '0;
         act_r_q  <= DIV_W'(DEFAULT_DIV);
         pend_r_q <= DIV_W'(DEFAULT_DIV);
         pend_v_q <= 1'b0;
         en_q     <= 1'b0;
         clk_q    <= 1'b0;
         oe_n_q   <= 1'b1;
         tick_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         act_r_q  <= act_r_d;
         pend_r_q <= pend_r_d;
         pend_v_q <= pend_v_d;
         en_q     <= en_d;
         clk_q    <= clk_d;
         oe_n_q   <= oe_n_d;
         tick_q   <= tick_d;
      end
   end

   assign clk_out  = clk_q;
   assign clk_oe_n = oe_n_q;
   assign tick     = tick_q;
   assign running  = (state_q == ST_RUN);

endmodule

// File: rtl/clock_gen_multi.sv
// Multi-channel divided-clock generator: config write decode, write acknowledge,
// and CHANNELS independent clock_div_channel instances.
module clock_gen_multi
   import clock_gen_pkg::*;
#(
   parameter  int unsigned CHANNELS    = 4,
   parameter  int unsigned DIV_W       = DEFAULT_DIV_W,
   parameter  int unsigned DEFAULT_DIV = 0,
   localparam int unsigned CH_W        = ch_sel_w(CHANNELS)
) (
   input  logic                clk_in,
   input  logic                reset,
   input  logic                cfg_wr,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [DIV_W-1:0]    cfg_div,
   input  logic                cfg_en,
   output logic                cfg_ack,
   output logic [CHANNELS-1:0] clk_out,
   output logic [CHANNELS-1:0] clk_oe_n,
   output logic [CHANNELS-1:0] tick,
   output logic [CHANNELS-1:0] running
);

   logic                cfg_hit;
   logic [CHANNELS-1:0] ch_wr;
   logic                ack_q;

   // Select values at or beyond CHANNELS are dropped and never acknowledged.
   assign cfg_hit = cfg_wr && (32'(cfg_ch) < CHANNELS);

   always_comb begin
      ch_wr = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (cfg_hit && (cfg_ch == CH_W'(i))) begin
            ch_wr[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         ack_q <= 1'b0;
      end else begin
         ack_q <= cfg_hit;
      end
   end

   assign cfg_ack = ack_q;

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      clock_div_channel #(
         .DIV_W       (DIV_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk_in   (clk_in),
         .reset    (reset),
         .wr       (ch_wr[gi]),
         .wr_div   (cfg_div),
         .wr_en    (cfg_en),
         .clk_out  (clk_out[gi]),
         .clk_oe_n (clk_oe_n[gi]),
         .tick     (tick[gi]),
         .running  (running[gi])
      );
   end

endmodule

// File: tb/tb_clock_gen_multi.sv
// Directed bench for clock_gen_multi: start, ratio change, clean stop, bad select, async reset.
// Three channels so that a 2-bit select can address an out-of-range channel.
module tb_clock_gen_multi;

   localparam int unsigned CHANNELS = 3;
   localparam int unsigned DIV_W    = 8;
   localparam int unsigned CH_W     = 2;

   logic                clk_in;
   logic                reset;
   logic                cfg_wr;
   logic [CH_W-1:0]     cfg_ch;
   logic [DIV_W-1:0]    cfg_div;
   logic                cfg_en;
   logic                cfg_ack;
   logic [CHANNELS-1:0] clk_out;
   logic [CHANNELS-1:0] clk_oe_n;
   logic [CHANNELS-1:0] tick;
   logic [CHANNELS-1:0] running;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] got_clk, got_tick, got_run, got_oe;
   logic        prev_c0;

   clock_gen_multi #(
      .CHANNELS    (CHANNELS),
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (0)
   ) dut (
      .clk_in   (clk_in),
      .reset    (reset),
      .cfg_wr   (cfg_wr),
      .cfg_ch   (cfg_ch),
      .cfg_div  (cfg_div),
      .cfg_en   (cfg_en),
      .cfg_ack  (cfg_ack),
      .clk_out  (clk_out),
      .clk_oe_n (clk_oe_n),
      .tick     (tick),
      .running  (running)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called right after a falling edge; the write is sampled on the next rising edge.
   task automatic drive_wr(input logic [CH_W-1:0] ch, input logic [DIV_W-1:0] div,
                           input logic en);
      cfg_wr  = 1'b1;
      cfg_ch  = ch;
      cfg_div = div;
      cfg_en  = en;
   endtask

   initial begin
      reset   = 1'b1;
      cfg_wr  = 1'b0;
      cfg_ch  = '0;
      cfg_div = '0;
      cfg_en  = 1'b0;
      #2 reset = 1'b0;
      repeat (3) @(negedge clk_in);
      check("rst_clk_out", 32'(clk_out), 32'h0);
      check("rst_oe_n", 32'(clk_oe_n), 32'h7);
      check("rst_running", 32'(running), 32'h0);
      check("rst_tick", 32'(tick), 32'h0);
      check("rst_ack", 32'(cfg_ack), 32'h0);
      reset = 1'b1;

      // Idle after reset release
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_in);
         check("idle_clk_out", 32'(clk_out), 32'h0);
         check("idle_oe_n", 32'(clk_oe_n), 32'h7);
         check("idle_running", 32'(running), 32'h0);
      end

      // ch0 R=2: enters RUN one cycle after the write lands, rises 3 cycles later
      drive_wr(2'd0, 8'd2, 1'b1);
      @(negedge clk_in);
      cfg_wr = 1'b0;
      check("t2_ack", 32'(cfg_ack), 32'h1);
      check("t2_run_before", 32'(running[0]), 32'h0);
      check("t2_oe_before", 32'(clk_oe_n[0]), 32'h1);
      got_clk  = '0;
      got_tick = '0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk_in);
         if (i == 1) begin
            check("t2_running", 32'(running[0]), 32'h1);
            check("t2_oe_n", 32'(clk_oe_n[0]), 32'h0);
            check("t2_ack_pulse", 32'(cfg_ack), 32'h0);
         end
         got_clk  = {got_clk[30:0], clk_out[0]};
         got_tick = {got_tick[30:0], tick[0]};
      end
      check("t2_clk_pattern", got_clk, 32'b0001110001);
      check("t2_tick_pattern", got_tick, 32'b0001000001);

      // Mid-high-phase ratio change to R=0
      drive_wr(2'd0, 8'd0, 1'b1);
      got_clk  = '0;
      got_tick = '0;
      for (int i = 11; i <= 20; i++) begin
         @(negedge clk_in);
         if (i == 11) begin
            cfg_wr = 1'b0;
            check("t3_ack", 32'(cfg_ack), 32'h1);
         end
         got_clk  = {got_clk[30:0], clk_out[0]};
         got_tick = {got_tick[30:0], tick[0]};
      end
      check("t3_clk_pattern", got_clk, 32'b1101010101);
      check("t3_tick_pattern", got_tick, 32'b0001010101);

      // ch1 R=4, stop requested during its second low phase
      drive_wr(2'd1, 8'd4, 1'b1);
      @(negedge clk_in);
      cfg_wr = 1'b0;
      check("t4_ack", 32'(cfg_ack), 32'h1);
      check("t4_run_before", 32'(running[1]), 32'h0);
      got_clk = '0;
      got_run = '0;
      got_oe  = '0;
      for (int i = 1; i <= 22; i++) begin
         @(negedge clk_in);
         if (i == 13) cfg_wr = 1'b0;
         got_clk = {got_clk[30:0], clk_out[1]};
         got_run = {got_run[30:0], running[1]};
         got_oe  = {got_oe[30:0], clk_oe_n[1]};
         if (i == 12) drive_wr(2'd1, 8'd4, 1'b0);
      end
      check("t4_clk_pattern", got_clk, 32'b0000011111000001111100);
      check("t4_run_pattern", got_run, 32'b1111111111111111111100);
      check("t4_oe_pattern", got_oe, 32'b0000000000000000000001);

      // Out-of-range select must not touch any channel
      drive_wr(2'd3, 8'd1, 1'b1);
      @(negedge clk_in);
      cfg_wr = 1'b0;
      check("t5_no_ack", 32'(cfg_ack), 32'h0);
      repeat (3) @(negedge clk_in);
      check("t5_running", 32'(running), 32'h1);
      check("t5_oe_n", 32'(clk_oe_n), 32'h6);
      check("t5_no_ack_late", 32'(cfg_ack), 32'h0);
      prev_c0 = clk_out[0];
      @(negedge clk_in);
      check("t5_ch0_toggles", 32'(prev_c0 ^ clk_out[0]), 32'h1);

      // All channels running, then asynchronous reset between edges
      drive_wr(2'd1, 8'd1, 1'b1);
      @(negedge clk_in);
      drive_wr(2'd2, 8'd3, 1'b1);
      @(negedge clk_in);
      cfg_wr = 1'b0;
      repeat (10) @(negedge clk_in);
      check("t6_all_running", 32'(running), 32'h7);
      check("t6_all_oe", 32'(clk_oe_n), 32'h0);
      #2 reset = 1'b0;
      #1;
      check("t6_rst_clk_out", 32'(clk_out), 32'h0);
      check("t6_rst_oe_n", 32'(clk_oe_n), 32'h7);
      check("t6_rst_running", 32'(running), 32'h0);
      check("t6_rst_tick", 32'(tick), 32'h0);
      check("t6_rst_ack", 32'(cfg_ack), 32'h0);
      @(negedge clk_in);
      reset = 1'b1;
      repeat (4) @(negedge clk_in);
      check("t6_after_rst_running", 32'(running), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
